// File: rtl/ss_scroll_ctrl.sv
// Scroll controller for a 4-digit multiplexed seven-segment display: buffers an ASCII
// message, scans the digits one slot at a time and rotates the message left every few frames.
module ss_scroll_ctrl #(
    parameter int CLK_DIV       = 100,
    parameter int SCROLL_FRAMES = 64,
    parameter int MSG_LEN       = 16
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_wr_valid,
    input  logic [6:0] i_wr_char,
    input  logic       i_wr_last,
    output logic       o_wr_ready,
    input  logic       i_clr,
    output logic       o_busy,
    output logic [3:0] o_dig,
    output logic [6:0] o_char_out,
    output logic [1:0] o_state
);

    localparam int PW = $clog2(MSG_LEN);
    localparam int LW = $clog2(MSG_LEN + 1);
    localparam int CW = $clog2(CLK_DIV);
    localparam int FW = $clog2(SCROLL_FRAMES + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_SHOW  = 2'd2
    } state_t;

    // Write port: a character moves when i_wr_valid and o_wr_ready are both high on a
    // rising clock edge; the writer holds i_wr_valid and i_wr_char/i_wr_last until then.
    state_t          r_state;
    logic [6:0]      r_mem [MSG_LEN];
    logic [PW-1:0]   r_wr_ptr;
    logic [LW-1:0]   r_len;
    logic [PW-1:0]   r_offset;
    logic [PW-1:0]   r_idx;
    logic [1:0]      r_pos;
    logic [CW-1:0]   r_presc;
    logic [FW-1:0]   r_frame;
    logic [3:0]      r_dig;
    logic [6:0]      r_char;
    logic            r_busy;
    logic            r_wr_ready;

    logic            w_accept;
    logic            w_final;
    logic            w_tick;
    logic [1:0]      w_pos_next;
    logic            w_frame_end;
    logic [FW-1:0]   w_frame_inc;
    logic            w_scroll;
    logic [PW-1:0]   w_offset_inc;
    logic [PW-1:0]   w_offset_next;
    logic [PW-1:0]   w_idx_src;
    logic [PW-1:0]   w_idx_inc;

    assign w_accept    = (r_state == S_IDLE) & r_wr_ready & i_wr_valid & ~i_clr;
    assign w_final     = i_wr_last | (r_wr_ptr == PW'(MSG_LEN - 1));
    assign w_tick      = (r_presc == CW'(CLK_DIV - 1));
    assign w_pos_next  = r_pos + 2'd1;
    assign w_frame_end = w_tick & (r_pos == 2'd3);
    assign w_frame_inc = r_frame + FW'(1);
    assign w_scroll    = w_frame_end & (w_frame_inc == FW'(SCROLL_FRAMES));

    // Wrapping increments compare against len instead of dividing.
    assign w_offset_inc  = ((LW'(r_offset) + LW'(1)) == r_len) ? '0 : r_offset + PW'(1);
    assign w_offset_next = w_scroll ? w_offset_inc : r_offset;

    // r_idx is pre-advanced: it already names the character for the next slot.
    assign w_idx_src = w_frame_end ? w_offset_next : r_idx;
    assign w_idx_inc = ((LW'(w_idx_src) + LW'(1)) == r_len) ? '0 : w_idx_src + PW'(1);

    always_ff @(posedge i_clk) begin
        if (w_accept) begin
            r_mem[r_wr_ptr] <= i_wr_char;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_wr_ptr   <= '0;
            r_len      <= '0;
            r_offset   <= '0;
            r_idx      <= '0;
            r_pos      <= '0;
            r_presc    <= '0;
            r_frame    <= '0;
            r_dig      <= 4'b0000;
            r_char     <= 7'h20;
            r_busy     <= 1'b0;
            r_wr_ready <= 1'b0;
        end else if (i_clr) begin
            r_state    <= S_IDLE;
            r_wr_ptr   <= '0;
            r_dig      <= 4'b0000;
            r_char     <= 7'h20;
            r_busy     <= 1'b0;
            r_wr_ready <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_wr_ready <= 1'b1;
                    r_dig      <= 4'b0000;
                    r_char     <= 7'h20;
                    if (w_accept) begin
                        r_wr_ptr <= r_wr_ptr + PW'(1);
                        if (w_final) begin
                            r_len      <= LW'(r_wr_ptr) + LW'(1);
                            r_wr_ptr   <= '0;
                            r_state    <= S_START;
                            r_busy     <= 1'b1;
                            r_wr_ready <= 1'b0;
                        end
                    end
                end
                S_START: begin
                    r_wr_ready <= 1'b0;
                    r_busy     <= 1'b1;
                    r_offset   <= '0;
                    r_presc    <= '0;
                    r_pos      <= '0;
                    r_frame    <= '0;
                    r_dig      <= 4'b1000;
                    r_char     <= r_mem[0];
                    r_idx      <= (r_len == LW'(1)) ? '0 : PW'(1);
                    r_state    <= S_SHOW;
                end
                S_SHOW: begin
                    r_wr_ready <= 1'b0;
                    r_busy     <= 1'b1;
                    r_presc    <= w_tick ? '0 : r_presc + CW'(1);
                    if (w_tick) begin
                        r_pos  <= w_pos_next;
                        r_dig  <= 4'b1000 >> w_pos_next;
                        r_char <= r_mem[w_idx_src];
                        r_idx  <= w_idx_inc;
                        if (w_frame_end) begin
                            r_frame  <= w_scroll ? '0 : w_frame_inc;
                            r_offset <= w_offset_next;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_wr_ready = r_wr_ready;
    assign o_busy     = r_busy;
    assign o_dig      = r_dig;
    assign o_char_out = r_char;
    assign o_state    = r_state;

endmodule

// File: tb/tb_ss_scroll_ctrl.sv
// Bench for ss_scroll_ctrl: directed and random messages compared cycle by cycle against
// a slot/frame arithmetic model of the scrolling display.
module tb_ss_scroll_ctrl;

    localparam int CLK_DIV       = 4;
    localparam int SCROLL_FRAMES = 2;
    localparam int MSG_LEN       = 16;

    logic       clk;
    logic       rst;
    logic       wr_valid;
    logic [6:0] wr_char;
    logic       wr_last;
    logic       wr_ready;
    logic       clr;
    logic       busy;
    logic [3:0] dig;
    logic [6:0] char_out;
    logic [1:0] state_dbg;

    int checks   = 0;
    int failures = 0;

    logic [6:0] exp_q[$];

    ss_scroll_ctrl #(
        .CLK_DIV(CLK_DIV),
        .SCROLL_FRAMES(SCROLL_FRAMES),
        .MSG_LEN(MSG_LEN)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .i_wr_valid(wr_valid),
        .i_wr_char(wr_char),
        .i_wr_last(wr_last),
        .o_wr_ready(wr_ready),
        .i_clr(clr),
        .o_busy(busy),
        .o_dig(dig),
        .o_char_out(char_out),
        .o_state(state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // driver tasks
    task automatic write_char(input logic [6:0] c, input logic last);
        int n;
        wr_valid = 1'b1;
        wr_char  = c;
        wr_last  = last;
        n = 0;
        while (wr_ready !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        if (n == 20) chk("write_timeout", 32'(n), 32'd0);
        step();
        wr_valid = 1'b0;
        wr_last  = 1'b0;
    endtask

    task automatic write_msg(input logic use_last, input int max_gap);
        for (int i = 0; i < exp_q.size(); i++) begin
            write_char(exp_q[i], use_last && (i == exp_q.size() - 1));
            if (i != exp_q.size() - 1) begin
                int g;
                g = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
                for (int k = 0; k < g; k++) step();
            end
        end
        chk("start_wr_ready", 32'(wr_ready), 32'd0);
        chk("start_busy", 32'(busy), 32'd1);
        step();
    endtask

    // scoreboard: the display is a pure function of cycles since the first scan slot
    task automatic check_show(input string tag, input int ncycles);
        int slot, pos, frame, off, len;
        len = exp_q.size();
        for (int t = 0; t < ncycles; t++) begin
            slot  = t / CLK_DIV;
            pos   = slot % 4;
            frame = slot / 4;
            off   = (frame / SCROLL_FRAMES) % len;
            chk({tag, "_dig"}, 32'(dig), 32'(4'b1000 >> pos));
            chk({tag, "_char"}, 32'(char_out), 32'(exp_q[(off + pos) % len]));
            chk({tag, "_busy"}, 32'(busy), 32'd1);
            chk({tag, "_rdy"}, 32'(wr_ready), 32'd0);
            step();
        end
    endtask

    task automatic do_clr(input string tag);
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk({tag, "_dig"}, 32'(dig), 32'd0);
        chk({tag, "_char"}, 32'(char_out), 32'h20);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_rdy"}, 32'(wr_ready), 32'd1);
    endtask

    task automatic load_str(input string s);
        exp_q.delete();
        for (int i = 0; i < s.len(); i++) exp_q.push_back(7'(s[i]));
    endtask

    localparam int FRAME_CYC = 4 * CLK_DIV;

    initial begin
        rst      = 1'b1;
        wr_valid = 1'b0;
        wr_char  = 7'h00;
        wr_last  = 1'b0;
        clr      = 1'b0;
        #1;
        chk("rst_dig", 32'(dig), 32'd0);
        chk("rst_char", 32'(char_out), 32'h20);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rdy", 32'(wr_ready), 32'd0);
        step();
        step();
        rst = 1'b0;
        step();
        chk("post_rst_rdy", 32'(wr_ready), 32'd1);
        chk("post_rst_dig", 32'(dig), 32'd0);

        // HELLO scrolls through twelve frames, including the wrap back to H,E,L,L
        load_str("HELLO");
        write_msg(1'b1, 0);
        check_show("hello", 12 * FRAME_CYC);
        do_clr("clr_hello");

        // sixteen characters without wr_last start on their own; a 17th write is held off
        load_str("ABCDEFGHIJKLMNOP");
        write_msg(1'b0, 1);
        wr_valid = 1'b1;
        wr_char  = 7'h51;
        check_show("full16", 8 * FRAME_CYC);
        wr_valid = 1'b0;
        do_clr("clr_full");

        // single character fills every digit
        load_str("X");
        write_msg(1'b1, 0);
        check_show("single", 6 * FRAME_CYC);
        do_clr("clr_single");

        // clr during frame 3, then a two-character message
        load_str("HELLO");
        write_msg(1'b1, 0);
        check_show("hello_pre_clr", 2 * FRAME_CYC + 5);
        do_clr("clr_mid");
        load_str("AB");
        write_msg(1'b1, 0);
        check_show("ab", 6 * FRAME_CYC);

        // async reset mid-slot, then a clr+write pair that must be dropped
        rst = 1'b1;
        #1;
        chk("arst_dig", 32'(dig), 32'd0);
        chk("arst_char", 32'(char_out), 32'h20);
        chk("arst_busy", 32'(busy), 32'd0);
        step();
        rst = 1'b0;
        step();
        chk("arst_rdy", 32'(wr_ready), 32'd1);
        clr      = 1'b1;
        wr_valid = 1'b1;
        wr_char  = 7'h51;
        wr_last  = 1'b0;
        step();
        clr      = 1'b0;
        wr_valid = 1'b0;
        chk("drop_busy", 32'(busy), 32'd0);
        chk("drop_rdy", 32'(wr_ready), 32'd1);
        load_str("AB");
        write_msg(1'b1, 0);
        check_show("ab_after_drop", 4 * FRAME_CYC);
        do_clr("clr_drop");

        // random messages with random pacing
        for (int r = 0; r < 6; r++) begin
            int n;
            logic use_last;
            n = int'($urandom_range(1, MSG_LEN));
            exp_q.delete();
            for (int i = 0; i < n; i++) exp_q.push_back(7'($urandom_range(8'h21, 8'h7e)));
            use_last = (n < MSG_LEN) ? 1'b1 : 1'($urandom_range(0, 1));
            write_msg(use_last, 2);
            check_show("rand", FRAME_CYC * SCROLL_FRAMES * (n + 1));
            do_clr("clr_rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
